// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port memory arbiter:
//                FSM state encoding, port count, default bus widths and a
//                small one-hot helper used for the per-port pulse outputs.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Number of requesters served by the arbiter
    localparam int NUM_PORTS  = 2;

    // Default memory bus widths
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Turn a port index into a one-hot per-port strobe vector
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational winner selection between two requesters.
//                Build option MEM_ARB_ROUND_ROBIN_EN: when defined, a tie is
//                resolved in favour of the port not granted last; otherwise
//                port 0 has fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Tie goes to the port that did not win the previous grant
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = 1'b1;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not asking
    logic w_unused_last;
    assign w_unused_last = last;

    always_comb begin
        win = 1'b0;
        if (req1 && !req0) begin
            win = 1'b1;
        end
    end
`endif

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter in front of a single-ported data memory.
//                Each access takes an ACCESS cycle (grant pulse, memory
//                strobes driven) followed by a RESP cycle (completion pulse).
//                Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie
//                breaking instead of fixed port-0 priority (see arb_pick).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rsp_valid0,
    output logic [DATA_W-1:0] rdata0,
    // requester 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rdata1,
    // memory side
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    // status
    output logic              busy
);

    arb_state_t               r_state;
    logic                     r_sel;
    logic                     r_last;
    logic [NUM_PORTS-1:0]     r_gnt;
    logic [NUM_PORTS-1:0]     r_rsp;
    logic [DATA_W-1:0]        r_rdata0;
    logic [DATA_W-1:0]        r_rdata1;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [DATA_W-1:0]        r_mem_wdata;
    logic                     r_mem_we;
    logic                     r_mem_rd;
    logic                     r_busy;

    logic                     w_any_req;
    logic                     w_win;
    logic                     w_we;
    logic [ADDR_W-1:0]        w_addr;
    logic [DATA_W-1:0]        w_wdata;

    // Winner between the two current requests
    arb_pick u_arb_pick (
        .req0 (req0),
        .req1 (req1),
        .last (r_last),
        .win  (w_win)
    );

    assign w_any_req = req0 | req1;

    // Request fields of the port about to be granted
    assign w_we    = w_win ? we1    : we0;
    assign w_addr  = w_win ? addr1  : addr0;
    assign w_wdata = w_win ? wdata1 : wdata0;

    // Arbiter FSM; every output is registered so the async reset clears the
    // memory strobes immediately, aborting any write still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_gnt       <= '0;
            r_rsp       <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, RESP: begin
                    r_rsp <= '0;
                    if (w_any_req) begin
                        // Launch the next access straight from RESP so
                        // back-to-back traffic gets one slot per two cycles
                        r_state     <= ACCESS;
                        r_sel       <= w_win;
                        r_last      <= w_win;
                        r_gnt       <= port_onehot(w_win);
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_we    <= w_we;
                        r_mem_rd    <= ~w_we;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_gnt       <= '0;
                        r_busy      <= 1'b0;
                    end
                end

                ACCESS: begin
                    // Read data is combinational from the memory and is
                    // captured at the edge that closes the access cycle
                    if (r_mem_rd) begin
                        if (r_sel) begin
                            r_rdata1 <= mem_read_data;
                        end else begin
                            r_rdata0 <= mem_read_data;
                        end
                    end
                    r_state     <= RESP;
                    r_gnt       <= '0;
                    r_rsp       <= port_onehot(r_sel);
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_rd    <= 1'b0;
                    r_busy      <= 1'b1;
                end

                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= '0;
                    r_rsp       <= '0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_rd    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0            = r_gnt[0];
    assign gnt1            = r_gnt[1];
    assign rsp_valid0      = r_rsp[0];
    assign rsp_valid1      = r_rsp[1];
    assign rdata0          = r_rdata0;
    assign rdata1          = r_rdata1;
    assign mem_access_addr = r_mem_addr;
    assign mem_write_data  = r_mem_wdata;
    assign mem_write_en    = r_mem_we;
    assign mem_read        = r_mem_rd;
    assign busy            = r_busy;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with an 8-word memory.
//                Honours MEM_ARB_ROUND_ROBIN_EN in its reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_req   [2];
    logic        t_we    [2];
    logic [15:0] t_addr  [2];
    logic [15:0] t_wdata [2];

    logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read, busy;

    logic [15:0] tb_mem [8];
    logic        mem_load;

    int          n_vec = 0;
    int          n_err = 0;
    int          rsp_cnt = 0;

    // reference model state
    logic [15:0] ref_mem [8];
    logic [15:0] m_rdata [2];
    int          m_last;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (t_req[0]),
        .we0             (t_we[0]),
        .addr0           (t_addr[0]),
        .wdata0          (t_wdata[0]),
        .gnt0            (gnt0),
        .rsp_valid0      (rsp_valid0),
        .rdata0          (rdata0),
        .req1            (t_req[1]),
        .we1             (t_we[1]),
        .addr1           (t_addr[1]),
        .wdata1          (t_wdata[1]),
        .gnt1            (gnt1),
        .rsp_valid1      (rsp_valid1),
        .rdata1          (rdata1),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .busy            (busy)
    );

    function automatic logic [15:0] init_val(input int i);
        case (i)
            0: return 16'h1000;
            1: return 16'h2001;
            2: return 16'h3002;
            3: return 16'h00A5;
            4: return 16'h5004;
            5: return 16'h6005;
            6: return 16'h7006;
            default: return 16'h8007;
        endcase
    endfunction

    // behavioural memory: combinational read, write on posedge
    assign mem_read_data = tb_mem[mem_access_addr[2:0]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) tb_mem[i] <= init_val(i);
        end else if (mem_write_en) begin
            tb_mem[mem_access_addr[2:0]] <= mem_write_data;
        end
    end

    always @(posedge clk) if (rsp_valid0 | rsp_valid1) rsp_cnt <= rsp_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // winner the arbitration rules dictate for the given requests
    function automatic int model_pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [1:0] oh(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic drive(input int p, input bit we, input logic [15:0] a, input logic [15:0] d);
        t_req[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_wdata[p] = d;
    endtask

    // wait (bounded) for a grant pulse; returns at posedge+1 of ACCESS
    task automatic wait_grant(output int p, output bit ok);
        ok = 1'b0; p = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (gnt0 | gnt1) begin
                p = gnt1 ? 1 : 0; ok = 1'b1;
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL grant_timeout: got no gnt expected a gnt within 8 cycles");
        t_req[0] = 1'b0; t_req[1] = 1'b0;
    endtask

    // check the ACCESS cycle, update the model, then check the RESP cycle
    task automatic finish_grant(input int p, input bit keep);
        chk("gnt_onehot", {30'd0, gnt1, gnt0}, {30'd0, oh(p)});
        chk("mem_addr", {16'd0, mem_access_addr}, {16'd0, t_addr[p]});
        chk("mem_we", {31'd0, mem_write_en}, {31'd0, t_we[p]});
        chk("mem_rd", {31'd0, mem_read}, {31'd0, ~t_we[p]});
        chk("mem_wdata", {16'd0, mem_write_data}, {16'd0, t_wdata[p]});
        chk("busy_access", {31'd0, busy}, 32'd1);
        if (t_we[p]) ref_mem[t_addr[p][2:0]] = t_wdata[p];
        else         m_rdata[p] = ref_mem[t_addr[p][2:0]];
        m_last = p;
        @(posedge clk); #1;
        if (!keep) t_req[p] = 1'b0;
        chk("rsp_onehot", {30'd0, rsp_valid1, rsp_valid0}, {30'd0, oh(p)});
        chk("rdata0", {16'd0, rdata0}, {16'd0, m_rdata[0]});
        chk("rdata1", {16'd0, rdata1}, {16'd0, m_rdata[1]});
        chk("resp_quiet", {29'd0, gnt0 | gnt1, mem_write_en | mem_read,
                           |{mem_access_addr, mem_write_data}}, 32'd0);
    endtask

    // serve the requests currently driven (at most one per port) to completion
    task automatic serve_round(input bit r0, input bit r1);
        int first, p;
        bit ok;
        first = model_pick(r0, r1);
        wait_grant(p, ok);
        if (!ok) return;
        chk("grant_order", p, first);
        finish_grant(p, 1'b0);
        if (r0 && r1) begin
            wait_grant(p, ok);
            if (!ok) return;
            chk("grant_order2", p, 1 - first);
            finish_grant(p, 1'b0);
        end
        @(posedge clk); #1;
        chk("idle_after", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p, cnt_snap;
        bit ok;

        vecs[0] = '{0, 1'b0, 16'h0003, 16'h0000, 16'h00A5};
        vecs[1] = '{1, 1'b0, 16'h0001, 16'h0000, 16'h2001};
        vecs[2] = '{1, 1'b1, 16'h0005, 16'h1234, 16'h2001};
        vecs[3] = '{0, 1'b0, 16'h0005, 16'h0000, 16'h1234};
        vecs[4] = '{1, 1'b0, 16'h0009, 16'h0000, 16'h2001};
        vecs[5] = '{0, 1'b1, 16'hFFF7, 16'hBEEF, 16'h1234};
        vecs[6] = '{1, 1'b0, 16'h0007, 16'h0000, 16'hBEEF};

        for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
        m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1;

        // reset with both requests asserted: nothing may move
        rst = 1'b1; mem_load = 1'b1;
        drive(0, 1'b1, 16'h0001, 16'h5555);
        drive(1, 1'b1, 16'h0002, 16'h6666);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        chk("rst_mem", {14'd0, mem_write_en, mem_read, mem_access_addr | mem_write_data}, 32'd0);
        t_req[0] = 1'b0; t_req[1] = 1'b0;
        @(negedge clk); rst = 1'b0; mem_load = 1'b0;

        // idle: ten cycles with no requests
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("idle_quiet", {14'd0, busy, mem_write_en | mem_read,
                               mem_access_addr | mem_write_data}, 32'd0);
        end

        // directed table of single-port accesses
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            serve_round(vecs[i].port == 0, vecs[i].port == 1);
            if (vecs[i].port == 0) chk("tbl_rdata", {16'd0, rdata0}, {16'd0, vecs[i].exp_rd});
            else                   chk("tbl_rdata", {16'd0, rdata1}, {16'd0, vecs[i].exp_rd});
        end

        // reset pulsed in the middle of a write access
        @(negedge clk);
        drive(0, 1'b1, 16'h0002, 16'hFFFF);
        wait_grant(p, ok);
        if (ok) begin
            chk("abort_we_before", {31'd0, mem_write_en}, 32'd1);
            cnt_snap = rsp_cnt;
            #2 rst = 1'b1;
            #1;
            chk("abort_we_drop", {31'd0, mem_write_en}, 32'd0);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            t_req[0] = 1'b0;
            @(posedge clk);
            @(negedge clk); rst = 1'b0;
            m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
            repeat (4) @(posedge clk);
            #1;
            chk("abort_no_rsp", rsp_cnt, cnt_snap);
            chk("abort_mem2", {16'd0, tb_mem[2]}, {16'd0, ref_mem[2]});
            chk("abort_idle", {31'd0, busy}, 32'd0);
            chk("abort_rdata", {rdata1, rdata0}, 32'd0);
        end

        // both ports requesting continuously for four grants
        @(negedge clk);
        drive(0, 1'b0, 16'h0003, 16'h0000);
        drive(1, 1'b0, 16'h0006, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            int exp_p;
            exp_p = model_pick(1'b1, 1'b1);
            wait_grant(p, ok);
            if (!ok) break;
            chk("rr_order", p, exp_p);
            finish_grant(p, 1'b1);
        end
        t_req[0] = 1'b0; t_req[1] = 1'b0;
        @(posedge clk); #1;
        chk("rr_idle", {31'd0, busy}, 32'd0);

        // randomized rounds against the reference model
        for (int r = 0; r < 40; r++) begin
            int mask;
            mask = $urandom_range(1, 3);
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                if (mask[q])
                    drive(q, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            end
            serve_round(mask[0], mask[1]);
        end

        for (int i = 0; i < 8; i++) chk("final_mem", {16'd0, tb_mem[i]}, {16'd0, ref_mem[i]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
